inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch unit that sits downstream of the program counter register and acts as the requester on the instruction-memory port. It holds the fetch PC and issues one word-aligned read at a time to instruction memory. Returned instructions are buffered in a 2-entry queue and handed to decode over a valid/ready interface. Branch/jump redirects flush in-flight and buffered instructions.

## Interface
- XLEN, 32: address and instruction width.
- RESET_PC, 32'h0000_0000: fetch address after reset.
- BUF_DEPTH, 2: instruction buffer entries. Only the value 2 is supported.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  XLEN  new fetch target; bits [1:0] ignored (forced 0)
- imem_req_valid  out  1  read request pending
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  word-aligned read address
- imem_resp_valid  in  1  read data returned (always accepted)
- imem_resp_data  in  XLEN  instruction word
- inst_valid  out  1  buffer head valid
- inst_ready  in  1  decode consumes head
- inst_data  out  XLEN  head instruction
- inst_pc  out  XLEN  PC of head instruction

## Operation
- Reset values:
  - fetch_pc = RESET_PC; state = REQ; buffer empty.
  - imem_req_valid = 0, inst_valid = 0, imem_req_addr = RESET_PC, inst_data = 0, inst_pc = 0.
- States:
  - REQ: imem_req_valid = 1 when (count + 0) < 2; imem_req_addr = fetch_pc.
    - On req handshake: latch req_pc = fetch_pc; fetch_pc += 4; go to WAIT.
  - WAIT: imem_req_valid = 0.
    - On imem_resp_valid: push {req_pc, data}; go to REQ.
  - DRAIN: one stale response is outstanding.
    - On imem_resp_valid: drop it and go to REQ; nothing is pushed.
- Space rule: a request issues only if count + outstanding < 2. This guarantees a push never overflows.
- Buffer is a 2-entry FIFO:
  - Pop on inst_valid && inst_ready.
  - Simultaneous push and pop is allowed at any count, and count is unchanged.
- Redirect has priority over every other event in the same cycle:
  - Buffer is cleared, and a same-cycle pop is ignored.
  - fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - If in WAIT and no response this cycle, go to DRAIN.
  - If in WAIT with a response this cycle, drop the response and go to REQ.
  - If in REQ with a same-cycle handshake, that request becomes outstanding-stale and the state goes to DRAIN.
  - If in DRAIN, stay in DRAIN unless the response arrives this cycle (then REQ).
  - Otherwise go to REQ.
- An un-accepted request may change address on redirect; the memory samples addr only on handshake.
- PC arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC + 4 wraps to 0.
- imem_resp_valid while in REQ (nothing outstanding) is ignored; the bench flags it as a protocol error.
- Reset asserted mid-operation returns everything to reset values immediately. Any response arriving after reset deasserts with nothing outstanding is ignored.

## Timing
- First imem_req_valid is in the first clock after reset deasserts.
- Request-to-response latency is ≥ 1 cycle.
- Response-to-inst_valid is 1 cycle, because the buffer is registered.
- Peak throughput is one instruction per 2 cycles with a 1-cycle memory.
- Redirect in cycle N:
  - inst_valid = 0 in cycle N+1.
  - imem_req_valid with the redirect address in N+1, unless in DRAIN. From DRAIN it follows the cycle after the stale response.
- imem_req_valid and imem_req_addr are driven from registers and state only. They have no combinational path from imem_req_ready.

## Structure
- Shared package riscv_pkg holds XLEN, RESET_PC, the fetch state enum (REQ, WAIT, DRAIN) and the fetch-entry struct {pc, inst}.
- Sub-module fetch_buffer: 2-entry FIFO with push/pop/flush, count output, and same-cycle push+pop support.
- inst_fetch holds the state machine, fetch_pc, req_pc and the space/redirect logic.

## Test plan
- Reset release, memory ready=1 with 1-cycle latency, decode ready=1:
  - Requests go to 0x0, 0x4, 0x8.
  - inst_pc/inst_data match memory, with one instruction every 2 cycles.
- Decode ready=0:
  - Exactly two requests are issued (0x0, 0x4), then imem_req_valid stays 0.
  - After ready=1 for one pop, the next request goes to 0x8.
- Redirect to 0x0000_0103 while in WAIT:
  - The stale response is dropped and the buffer is empty.
  - The next request goes to 0x0000_0100 and the first inst_pc is 0x100.
- Redirect in the same cycle as a response and a pop, with count=1:
  - Nothing is pushed and count becomes 0.
  - Request to the redirect address in the next cycle.
- Redirect to 0xFFFF_FFFC:
  - Requests go to 0xFFFF_FFFC, then 0x0000_0000.
- Reset asserted while in DRAIN with an outstanding request:
  - Outputs return to reset values immediately.
  - A late response is ignored, and the first request is to RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-path types: widths, reset PC, fetch FSM states and buffer entry layout.
package riscv_pkg;
  localparam int XLEN      = 32;
  localparam int BUF_DEPTH = 2;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_buffer.sv
// Two-entry instruction FIFO with flush and same-cycle push+pop at any occupancy.
module fetch_buffer import riscv_pkg::*; (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [1:0]   count_next,
  output fetch_entry_t head
);
  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;

  // Next-state: flush wins; when full, a push reuses the slot being popped.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;
  assign head       = mem_q[rd_ptr_q];
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding imem read, 2-entry decode buffer, redirect flush
// with a DRAIN state that swallows the response of a request made stale by a redirect.
module inst_fetch import riscv_pkg::*; (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            req_valid_q, req_valid_d;
  logic            req_fire, push, pop;
  logic [1:0]      count, count_next;
  fetch_entry_t    push_entry, head;
  logic            redirect_pc_unused;

  assign redirect_pc_unused = ^redirect_pc[1:0];
  assign req_fire   = req_valid_q & imem_req_ready;
  assign pop        = inst_valid & inst_ready & ~redirect_valid;
  assign push       = (state_q == WAIT) & imem_resp_valid & ~redirect_valid;
  assign push_entry = '{pc: req_pc_q, inst: imem_resp_data};

  // FSM next-state; a redirect overrides every other event this cycle.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    case (state_q)
      REQ: begin
        if (req_fire) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = pc_next(fetch_pc_q);
          state_d    = WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT, DRAIN: begin
        if (imem_resp_valid) begin
          state_d = REQ;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = REQ;
    endcase
    if (redirect_valid) begin
      fetch_pc_d = pc_align(redirect_pc);
      case (state_q)
        REQ:         state_d = req_fire ? DRAIN : REQ;
        WAIT, DRAIN: state_d = imem_resp_valid ? REQ : DRAIN;
        default:     state_d = REQ;
      endcase
    end else begin
      fetch_pc_d = fetch_pc_d;
    end
  end

  // Request is registered so it never depends combinationally on imem_req_ready.
  assign req_valid_d = (state_d == REQ) && (count_next < 2'(BUF_DEPTH));

  // State and request registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= REQ;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= RESET_PC;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
    end
  end

  fetch_buffer u_buf (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (count),
    .count_next (count_next),
    .head       (head)
  );

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = fetch_pc_q;
  assign inst_valid     = (count != 2'd0);
  assign inst_data      = head.inst;
  assign inst_pc        = head.pc;
endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: transaction-level queue model plus directed scenarios.
module tb_inst_fetch;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'd0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  inst_fetch dut (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of decoded-ready entries, one outstanding flag, stale flag.
  ent_t        m_q[$];
  bit          m_live, m_out, m_stale;
  logic [31:0] m_pc, m_req_pc;

  // Memory stimulus: one pending read with a countdown.
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'd0;
  int          lat_min = 1, lat_max = 1;
  logic [31:0] hs_log[$];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(3))
      0: return 32'h0000_0103;
      1: return 32'hFFFF_FFFE;
      2: return $urandom();
      default: return $urandom() & 32'h0000_0FFF;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_live = 1'b0; m_out = 1'b0; m_stale = 1'b0;
    m_pc = 32'h0000_0000; m_req_pc = 32'h0000_0000;
  endtask

  task automatic model_step();
    bit fire, pop, resp;
    fire = m_live && !m_out && (m_q.size() < 2) && imem_req_ready;
    pop  = (m_q.size() > 0) && inst_ready;
    resp = m_out && imem_resp_valid;
    if (redirect_valid) begin
      m_q.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
      if (m_out) begin
        m_out = !imem_resp_valid;
        m_stale = m_out;
      end else if (fire) begin
        m_out = 1'b1;
        m_stale = 1'b1;
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (resp) begin
        if (!m_stale) m_q.push_back('{pc: m_req_pc, inst: memfn(m_req_pc)});
        m_out = 1'b0;
        m_stale = 1'b0;
      end
      if (fire) begin
        m_req_pc = m_pc;
        m_pc = m_pc + 32'd4;
        m_out = 1'b1;
        m_stale = 1'b0;
      end
    end
    m_live = 1'b1;
  endtask

  task automatic compare_outputs();
    bit exp_rv;
    exp_rv = m_live && !m_out && (m_q.size() < 2);
    check_eq("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
    check_eq("req_addr", imem_req_addr, m_pc);
    check_eq("inst_valid", {31'd0, inst_valid}, {31'd0, m_q.size() > 0});
    if (m_q.size() > 0) begin
      check_eq("inst_pc", inst_pc, m_q[0].pc);
      check_eq("inst_data", inst_data, m_q[0].inst);
    end
  endtask

  // One clock: check at negedge, drive inputs, update model/memory at posedge.
  task automatic cycle(input logic rdy, input logic ird, input logic redir, input logic [31:0] rpc);
    bit resp, hs;
    logic [31:0] hs_addr;
    @(negedge clock);
    compare_outputs();
    resp = mem_busy && (mem_cnt == 0);
    imem_resp_valid = resp;
    imem_resp_data  = resp ? memfn(mem_addr) : $urandom();
    imem_req_ready  = rdy;
    inst_ready      = ird;
    redirect_valid  = redir;
    redirect_pc     = rpc;
    hs      = imem_req_valid && rdy;
    hs_addr = imem_req_addr;
    @(posedge clock);
    if (reset) model_reset(); else model_step();
    if (resp) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (hs && !reset) begin
      mem_busy = 1'b1;
      mem_addr = hs_addr;
      mem_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
      hs_log.push_back(hs_addr);
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    mem_busy = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    reset = 1'b0;
    hs_log.delete();
  endtask

  initial begin
    model_reset();
    // Reset values while reset is held.
    #2;
    check_eq("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check_eq("rst_req_addr", imem_req_addr, 32'h0000_0000);
    check_eq("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check_eq("rst_inst_data", inst_data, 32'd0);
    check_eq("rst_inst_pc", inst_pc, 32'd0);

    // Streaming: 1-cycle memory, decode always ready.
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
    check_eq("stream_req_count", hs_log.size(), 32'd6);
    check_eq("stream_req0", hs_log.size() > 0 ? hs_log[0] : 32'hDEAD_BEEF, 32'h0);
    check_eq("stream_req1", hs_log.size() > 1 ? hs_log[1] : 32'hDEAD_BEEF, 32'h4);
    check_eq("stream_req2", hs_log.size() > 2 ? hs_log[2] : 32'hDEAD_BEEF, 32'h8);

    // Decode stalled: exactly two requests, then one pop lets 0x8 out.
    do_reset();
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check_eq("stall_req_count", hs_log.size(), 32'd2);
    check_eq("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check_eq("stall_next_req", hs_log.size() > 2 ? hs_log[2] : 32'hDEAD_BEEF, 32'h8);

    // Redirect to 0x103 while a 3-cycle read is in flight.
    lat_min = 3; lat_max = 3;
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    hs_log.delete();
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    for (int i = 0; i < 20 && !inst_valid; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check_eq("redir_first_req", hs_log.size() > 0 ? hs_log[0] : 32'hDEAD_BEEF, 32'h100);
    check_eq("redir_first_pc", inst_valid ? inst_pc : 32'hDEAD_BEEF, 32'h100);

    // Redirect coinciding with a response and a pop at count=1.
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    check_eq("rrp_inst_valid", {31'd0, inst_valid}, 32'd0);
    check_eq("rrp_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check_eq("rrp_req_addr", imem_req_addr, 32'h0000_0200);

    // Wrap from the top of the address space.
    do_reset();
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
    check_eq("wrap_req0", hs_log.size() > 0 ? hs_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    check_eq("wrap_req1", hs_log.size() > 1 ? hs_log[1] : 32'hDEAD_BEEF, 32'h0000_0000);

    // Reset while draining a stale read; the late response must be ignored.
    lat_min = 4; lat_max = 4;
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0040);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check_eq("mid_rst_req_addr", imem_req_addr, 32'h0000_0000);
    check_eq("mid_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check_eq("mid_rst_inst_pc", inst_pc, 32'd0);
    model_reset();
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    reset = 1'b0;
    hs_log.delete();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check_eq("post_rst_req", hs_log.size() > 0 ? hs_log[0] : 32'hDEAD_BEEF, 32'h0000_0000);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) begin
        lat_min = 1;
        lat_max = int'($urandom_range(3, 1));
      end
      cycle($urandom_range(99) < 70, $urandom_range(99) < 60,
            $urandom_range(99) < 8, pick_pc());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
